// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if
// Bundles the two requester channels and the shared-multiplier channel of
// mult_arbiter.
//   slave  : arbiter view (takes requests and mul_y/mul_done, drives
//            results, done pulses and the multiplier operands/start)
//   master : environment view (requesters plus the multiplier)
// Signals:
//   req0_valid/req1_valid, req0_a/b, req1_a/b, req0_signed/req1_signed
//   req0_done/req1_done, res0_y/res1_y
//   mul_a, mul_b, mul_start, mul_y, mul_done, busy
interface mult_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_signed;
  logic        req1_signed;
  logic        req0_done;
  logic        req1_done;
  logic [63:0] res0_y;
  logic [63:0] res1_y;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic [63:0] mul_y;
  logic        mul_done;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_signed, req1_signed, mul_y, mul_done,
    output req0_done, req1_done, res0_y, res1_y,
    output mul_a, mul_b, mul_start, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_signed, req1_signed, mul_y, mul_done,
    input  req0_done, req1_done, res0_y, res1_y,
    input  mul_a, mul_b, mul_start, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter
// Shares one external multiplier between two requesters with round-robin
// arbitration. Sequence per operation: IDLE (grant + latch operands) ->
// ISSUE (mul_start) -> WAIT (until mul_done, capture result) -> DONE
// (one-cycle done pulse to the granted requester) -> IDLE.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mult_arbiter_if.slave (requests, results, multiplier channel)
// Optional feature: define MULT_ARB_SIGNED_EN to honour reqN_signed. The
// multiplier then sees operand magnitudes and the product is negated when
// the operand signs differ. Without it the signed flags are ignored.
module mult_arbiter (
  input  logic           clk,
  input  logic           reset_n,
  mult_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_reg;
  logic        last_grant_reg;
  logic        gnt_id_reg;
  logic [31:0] mul_a_reg;
  logic [31:0] mul_b_reg;
  logic [63:0] res0_reg;
  logic [63:0] res1_reg;

  logic        any_valid;
  logic        gnt_next;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] prod;

  // On a tie the requester not granted last wins; otherwise the lone one.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign gnt_next  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_reg
                                                       : bus.req1_valid;
  assign sel_a     = gnt_next ? bus.req1_a : bus.req0_a;
  assign sel_b     = gnt_next ? bus.req1_b : bus.req0_b;

`ifdef MULT_ARB_SIGNED_EN
  logic sel_signed;
  logic neg_next;
  logic neg_reg;

  assign sel_signed = gnt_next ? bus.req1_signed : bus.req0_signed;
  // Magnitudes; -2^31 negates to itself, which read unsigned is 2^31.
  assign op_a     = (sel_signed & sel_a[31]) ? (~sel_a + 32'd1) : sel_a;
  assign op_b     = (sel_signed & sel_b[31]) ? (~sel_b + 32'd1) : sel_b;
  assign neg_next = sel_signed & (sel_a[31] ^ sel_b[31]);
  assign prod     = neg_reg ? (~bus.mul_y + 64'd1) : bus.mul_y;
`else
  assign op_a = sel_a;
  assign op_b = sel_b;
  assign prod = bus.mul_y;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      gnt_id_reg     <= 1'b0;
      mul_a_reg      <= 32'd0;
      mul_b_reg      <= 32'd0;
      res0_reg       <= 64'd0;
      res1_reg       <= 64'd0;
`ifdef MULT_ARB_SIGNED_EN
      neg_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            state_reg      <= ISSUE;
            gnt_id_reg     <= gnt_next;
            last_grant_reg <= gnt_next;
            mul_a_reg      <= op_a;
            mul_b_reg      <= op_b;
`ifdef MULT_ARB_SIGNED_EN
            neg_reg        <= neg_next;
`endif
          end
        end
        ISSUE: state_reg <= WAIT;
        // mul_done is only looked at here; pulses in other states are dropped.
        WAIT: begin
          if (bus.mul_done) begin
            if (gnt_id_reg) res1_reg <= prod;
            else            res0_reg <= prod;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mul_start = (state_reg == ISSUE);
  assign bus.req0_done = (state_reg == DONE) & ~gnt_id_reg;
  assign bus.req1_done = (state_reg == DONE) &  gnt_id_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign bus.res0_y    = res0_reg;
  assign bus.res1_y    = res1_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
// Directed bench for mult_arbiter with a behavioural multiplier that raises
// mul_done so it is sampled 5 cycles after mul_start is sampled. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mult_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_arbiter_if ifc ();

  mult_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  // Behavioural multiplier
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [63:0] model_y = 64'd0;
  int          mcnt = 0;
  assign ifc.mul_done = model_done | stray_done;
  assign ifc.mul_y    = model_y;

  always @(posedge clk) begin
    if (!reset_n) begin
      mcnt       <= 0;
      model_done <= 1'b0;
    end else begin
      if (mcnt == 1) begin
        model_done <= 1'b1;
        model_y    <= {32'd0, ifc.mul_a} * {32'd0, ifc.mul_b};
      end else begin
        model_done <= 1'b0;
      end
      if (ifc.mul_start)  mcnt <= 4;
      else if (mcnt != 0) mcnt <= mcnt - 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until the chosen requester's done is seen (n=0 on
  // timeout); also records mul_start activity and any done on the other side.
  task automatic wait_done(input int which, output int n, output int starts,
                           output int first_start, output bit other);
    n = 0; starts = 0; first_start = 0; other = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ifc.mul_start) begin
        starts++;
        if (first_start == 0) first_start = i;
      end
      if ((which == 0) ? ifc.req1_done : ifc.req0_done) other = 1'b1;
      if ((which == 0) ? ifc.req0_done : ifc.req1_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_either(output int who);
    who = 2;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ifc.req0_done) begin who = 0; break; end
      if (ifc.req1_done) begin who = 1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, fs, who;
    bit oth, flag;
    logic [31:0] a0, b0, a1, b1;
    logic [63:0] exp_res0, exp_res1;

    ifc.req0_valid = 0; ifc.req1_valid = 0;
    ifc.req0_a = 0; ifc.req0_b = 0; ifc.req1_a = 0; ifc.req1_b = 0;
    ifc.req0_signed = 0; ifc.req1_signed = 0;

    // Reset state
    #2;
    check("rst_busy", {63'd0, ifc.busy}, 64'd0);
    check("rst_start", {63'd0, ifc.mul_start}, 64'd0);
    check("rst_done", {62'd0, ifc.req1_done, ifc.req0_done}, 64'd0);
    check("rst_mul_ab", {ifc.mul_a, ifc.mul_b}, 64'd0);
    check("rst_res0", ifc.res0_y, 64'd0);
    check("rst_res1", ifc.res1_y, 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    // Single request 7x6
    @(negedge clk);
    ifc.req0_a = 7; ifc.req0_b = 6; ifc.req0_valid = 1;
    wait_done(0, n, st, fs, oth);
    check("single_lat", n, 7);
    check("single_start_at", fs, 1);
    check("single_start_len", st, 1);
    check("single_other", {63'd0, oth}, 64'd0);
    check("single_res0", ifc.res0_y, 64'd42);
    check("single_res1", ifc.res1_y, 64'd0);
    ifc.req0_valid = 0;
    @(negedge clk);
    check("single_idle_busy", {63'd0, ifc.busy}, 64'd0);
    check("single_done_len", {63'd0, ifc.req0_done}, 64'd0);

    // Operands change and valid drops right after grant
    ifc.req1_a = 9; ifc.req1_b = 9; ifc.req1_valid = 1;
    @(negedge clk);
    check("chg_mul_a", {32'd0, ifc.mul_a}, 64'd9);
    ifc.req1_valid = 0; ifc.req1_a = 1; ifc.req1_b = 1;
    wait_done(1, n, st, fs, oth);
    check("chg_lat", n, 6);
    check("chg_res1", ifc.res1_y, 64'd81);
    check("chg_res0_kept", ifc.res0_y, 64'd42);

    // Simultaneous requests straight from reset
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    check("rst2_res0", ifc.res0_y, 64'd0);
    check("rst2_res1", ifc.res1_y, 64'd0);
    reset_n = 1;
    ifc.req0_a = 3; ifc.req0_b = 4; ifc.req1_a = 5; ifc.req1_b = 5;
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    wait_done(0, n, st, fs, oth);
    check("tie_first_lat", n, 7);
    check("tie_first_other", {63'd0, oth}, 64'd0);
    check("tie_res0", ifc.res0_y, 64'd12);
    ifc.req0_valid = 0;
    wait_done(1, n, st, fs, oth);
    check("tie_gap", n, 8);
    check("tie_second_start_at", fs, 2);
    check("tie_res1", ifc.res1_y, 64'd25);
    check("tie_res0_kept", ifc.res0_y, 64'd12);
    ifc.req1_valid = 0;

    // Fairness: both keep re-requesting, grants must alternate 0,1,0,1...
    @(negedge clk);
    a0 = 2; b0 = 3; a1 = 10; b1 = 1;
    ifc.req0_a = a0; ifc.req0_b = b0; ifc.req1_a = a1; ifc.req1_b = b1;
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    exp_res0 = 0;
    for (int k = 0; k < 8; k++) begin
      wait_either(who);
      check($sformatf("fair_grant%0d", k), who, k % 2);
      if (who == 0) begin
        exp_res0 = {32'd0, a0} * {32'd0, b0};
        check($sformatf("fair_res0_%0d", k), ifc.res0_y, exp_res0);
        ifc.req0_valid = 0;
        @(negedge clk);
        a0 = a0 + 1;
        ifc.req0_a = a0;
        if (k < 6) ifc.req0_valid = 1;
      end else begin
        check($sformatf("fair_res1_%0d", k), ifc.res1_y, {32'd0, a1} * {32'd0, b1});
        ifc.req1_valid = 0;
        @(negedge clk);
        a1 = a1 + 3; b1 = b1 + 2;
        ifc.req1_a = a1; ifc.req1_b = b1;
        if (k < 6) ifc.req1_valid = 1;
      end
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0;

    // Signed request: -3 x 7 from requester 1
    @(negedge clk);
    ifc.req1_signed = 1; ifc.req1_a = 32'hFFFF_FFFD; ifc.req1_b = 7; ifc.req1_valid = 1;
    @(negedge clk);
`ifdef MULT_ARB_SIGNED_EN
    check("sgn_mul_a", {32'd0, ifc.mul_a}, 64'd3);
    exp_res1 = 64'hFFFF_FFFF_FFFF_FFEB;
`else
    check("sgn_mul_a", {32'd0, ifc.mul_a}, 64'h0000_0000_FFFF_FFFD);
    exp_res1 = 64'h0000_0006_FFFF_FFEB;
`endif
    wait_done(1, n, st, fs, oth);
    check("sgn_lat", n, 6);
    check("sgn_res1", ifc.res1_y, exp_res1);
    ifc.req1_valid = 0; ifc.req1_signed = 0;

    // Stray mul_done while idle
    @(negedge clk);
    @(negedge clk);
    stray_done = 1;
    @(negedge clk);
    stray_done = 0;
    check("stray_busy", {63'd0, ifc.busy}, 64'd0);
    check("stray_done", {62'd0, ifc.req1_done, ifc.req0_done}, 64'd0);
    @(negedge clk);
    check("stray_busy2", {63'd0, ifc.busy}, 64'd0);
    check("stray_res0", ifc.res0_y, exp_res0);
    check("stray_res1", ifc.res1_y, exp_res1);

    // Asynchronous reset while waiting on the multiplier
    ifc.req0_a = 8; ifc.req0_b = 8; ifc.req0_valid = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("wait_busy", {63'd0, ifc.busy}, 64'd1);
    #2 reset_n = 0;
    #1;
    check("arst_busy", {63'd0, ifc.busy}, 64'd0);
    check("arst_mul_ab", {ifc.mul_a, ifc.mul_b}, 64'd0);
    check("arst_res0", ifc.res0_y, 64'd0);
    check("arst_res1", ifc.res1_y, 64'd0);
    ifc.req0_valid = 0;
    @(negedge clk);
    reset_n = 1;
    flag = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.req0_done || ifc.req1_done || ifc.busy) flag = 1;
    end
    check("arst_no_done", {63'd0, flag}, 64'd0);
    ifc.req0_a = 2; ifc.req0_b = 2; ifc.req0_valid = 1;
    wait_done(0, n, st, fs, oth);
    check("post_rst_lat", n, 7);
    check("post_rst_res0", ifc.res0_y, 64'd4);
    ifc.req0_valid = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: request held high until the matching done pulse.
REQ-004 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 bits each: operands.
REQ-005 The block SHALL have ports req0_signed / req1_signed, input, 1 bit each: two's-complement operands (honoured only with MULT_ARB_SIGNED_EN).
REQ-006 The block SHALL have ports req0_done / req1_done, output, 1 bit each: one-cycle completion pulse.
REQ-007 The block SHALL have ports res0_y / res1_y, output, 64 bits each: registered product, held until the next completion for that requester.
REQ-008 The block SHALL have ports mul_a / mul_b, output, 32 bits each: operands to the shared multiplier, held stable from grant until mul_done.
REQ-009 The block SHALL have port mul_start, output, 1 bit: single-cycle start to the multiplier.
REQ-010 The block SHALL have ports mul_y (input, 64 bits) and mul_done (input, 1 bit): multiplier result and its completion pulse.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The FSM SHALL have four states, IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with no other transitions.
REQ-013 In IDLE, with any reqN_valid high, the block SHALL grant one requester and latch its operands, signed flag and id at that edge, then move to ISSUE.
REQ-014 Arbitration SHALL be round-robin: if only one requester is valid, it wins; if both are valid, the requester not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-015 mul_start SHALL be high for exactly the one cycle spent in ISSUE.
REQ-016 WAIT SHALL hold until mul_done=1; at that edge the block SHALL register the (sign-corrected) mul_y into resN_y of the granted requester and move to DONE.
REQ-017 In DONE, reqN_done of the granted requester SHALL be high for exactly one cycle; the other requester's done and result SHALL stay unchanged.
REQ-018 A requester SHALL drop valid on the edge where it samples done=1, so IDLE never re-grants a completed request.
REQ-019 mul_done outside WAIT SHALL be ignored.
REQ-020 Request inputs changing after grant SHALL NOT affect the operation in flight.
REQ-021 If valid drops before done, the operation SHALL still complete and pulse done.
REQ-022 With a multiplier whose mul_done arrives 5 cycles after mul_start is sampled, reqN_done SHALL appear 7 cycles after the granting edge.
REQ-023 Back-to-back service SHALL cost one IDLE cycle between operations.

Reset
REQ-024 On reset_n=0, asynchronously: state=IDLE, last_grant=1, mul_a=mul_b=0, mul_start=0, req0_done=req1_done=0, res0_y=res1_y=0, busy=0.
REQ-025 Reset mid-operation SHALL abandon the operation: no done pulse, results zeroed; after release, the block SHALL start in IDLE.

Configuration
REQ-026 With MULT_ARB_SIGNED_EN defined and the granted signed flag set, mul_a/mul_b SHALL be the operand magnitudes (-2^31 gives 0x80000000), and the 64-bit result SHALL be two's-complement negated when the operand signs differ.
REQ-027 Without MULT_ARB_SIGNED_EN, reqN_signed SHALL be ignored, operands SHALL pass unmodified, and mul_y SHALL pass through unmodified.

Verification
REQ-028 Single request: req0 a=7, b=6 -> mul_start one cycle after grant; req0_done 7 cycles after grant; res0_y=42.
REQ-029 Simultaneous requests from reset: req0 (3x4) and req1 (5x5) -> req0 served first (res0_y=12), then req1 (res1_y=25); done pulses 8 cycles apart.
REQ-030 Fairness: both valid continuously with 4 re-requests each -> grants strictly alternate 0,1,0,1...; no starvation.
REQ-031 Signed with MULT_ARB_SIGNED_EN: req1 signed, a=-3, b=7 -> res1_y=0xFFFFFFFFFFFFFFEB; same stimulus without the macro -> res1_y=0x6FFFFFFEB.
REQ-032 Async reset asserted in WAIT -> busy=0 and outputs 0 immediately, no done pulse; a new req0 2x2 after release -> res0_y=4.
REQ-033 Stray mul_done pulse in IDLE -> no state change, no done pulse, results unchanged.
